// File: rtl/cdc_pkg.sv
// Shared types and constants for the multi-bit CDC receive path.
//   state_e             : four-phase handshake FSM states
//   DEFAULT_SYNC_STAGES : default depth of the req synchroniser
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low reset.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : asynchronous input bit
//   q_o    : synchronised output, STAGES clk_i edges behind d_i
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_bus_rx.sv
// Receive side of a req/ack multi-bit clock-domain crossing.
// The sender's req is synchronised; its data bus is sampled only on a
// capture, when the handshake guarantees it is stable. Captured words are
// presented on a valid/ready stream; no word is acknowledged while the
// output register is still occupied.
// Ports:
//   clk_i        : local clock
//   rst_ni       : asynchronous active-low reset
//   async_req_i  : sender request (level in four-phase, toggle in two-phase)
//   async_data_i : sender data, stable while the request is outstanding
//   async_ack_o  : registered acknowledge back to the sender
//   data_o       : captured word
//   valid_o      : data_o holds an unconsumed word
//   ready_i      : consumer accepts data_o when valid_o is high
//   busy_o       : handshake in progress or output occupied
//   xfer_cnt_o   : number of captured words, wraps modulo 2^CNT_W
module cdc_bus_rx
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned TOGGLE_MODE = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             async_req_i,
  input  logic [WIDTH-1:0] async_data_i,
  output logic             async_ack_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  state_e             state_q, state_d;
  logic               req_prev_q, req_prev_d;
  logic               ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_s;
  logic               slot_free;
  logic               pending;
  logic               capture;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (async_req_i),
    .q_o    (req_s)
  );

  // A pop and a capture may share a cycle: the new word overwrites the old.
  assign slot_free = !valid_q || ready_i;

  // In toggle mode an event stays pending until it can be captured, because
  // req_prev only follows req_s on a capture.
  assign pending = (TOGGLE_MODE != 0) ? (req_s != req_prev_q)
                                      : ((state_q == IDLE) && req_s);
  assign capture = pending && slot_free;

  always_comb begin
    state_d    = state_q;
    req_prev_d = req_prev_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    data_d     = data_q;
    cnt_d      = cnt_q;

    if (capture) begin
      data_d  = async_data_i;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (TOGGLE_MODE != 0) begin
        ack_d      = req_s;
        req_prev_d = req_s;
      end else begin
        ack_d   = 1'b1;
        state_d = WAIT_LOW;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if ((TOGGLE_MODE == 0) && (state_q == WAIT_LOW) && !req_s) begin
      ack_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign async_ack_o = ack_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign xfer_cnt_o  = cnt_q;
  assign busy_o      = (state_q != IDLE) || valid_q || pending;

endmodule

// File: tb/tb_cdc_bus_rx.sv
// Directed bench for cdc_bus_rx. Four instances share clock and reset:
//   0: four-phase, SYNC_STAGES=2, CNT_W=8
//   1: toggle,     SYNC_STAGES=2, CNT_W=8
//   2: four-phase, SYNC_STAGES=3, CNT_W=2
//   3: toggle,     SYNC_STAGES=3, CNT_W=2
module tb_cdc_bus_rx;

  logic       clk;
  logic       rst_n;
  logic       req   [4];
  logic [7:0] din   [4];
  logic       ack   [4];
  logic [7:0] dout  [4];
  logic       valid [4];
  logic       ready [4];
  logic       busy  [4];
  logic [7:0] cnt   [4];

  int unsigned n_pass;
  int unsigned n_total;
  logic [7:0]  expq [$];
  logic [7:0]  gotq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned CW = (g < 2) ? 8 : 2;
    logic [CW-1:0] c;
    cdc_bus_rx #(
      .WIDTH       (8),
      .SYNC_STAGES (2 + g / 2),
      .TOGGLE_MODE (g % 2),
      .CNT_W       (CW)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .async_req_i  (req[g]),
      .async_data_i (din[g]),
      .async_ack_o  (ack[g]),
      .data_o       (dout[g]),
      .valid_o      (valid[g]),
      .ready_i      (ready[g]),
      .busy_o       (busy[g]),
      .xfer_cnt_o   (c)
    );
    assign cnt[g] = 8'(c);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, input logic lvl);
    for (int n = 0; n < 64; n++) begin
      if (ack[k] == lvl) break;
      tick();
    end
    chk($sformatf("ack_wait%0d", k), 32'(ack[k]), 32'(lvl));
  endtask

  task automatic send(input int k, input logic [7:0] d);
    din[k] = d;
    if (k % 2 == 1) begin
      req[k] = ~req[k];
      wait_ack(k, req[k]);
    end else begin
      req[k] = 1'b1;
      wait_ack(k, 1'b1);
      req[k] = 1'b0;
      wait_ack(k, 1'b0);
    end
  endtask

  task automatic stress(input int k);
    expq.delete();
    gotq.delete();
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [7:0] d;
          d = 8'($urandom);
          expq.push_back(d);
          send(k, d);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        for (int n = 0; n < 20000 && gotq.size() < 100; n++) begin
          tick();
          ready[k] = 1'($urandom_range(0, 1));
          if (valid[k] && ready[k]) gotq.push_back(dout[k]);
        end
      end
    join
    ready[k] = 1'b1;
    repeat (8) tick();
    chk($sformatf("stress%0d_count", k), 32'(gotq.size()), 32'd100);
    chk($sformatf("stress%0d_extra", k), 32'(valid[k]), 32'd0);
    for (int i = 0; i < 100 && i < gotq.size(); i++)
      chk($sformatf("stress%0d_w%0d", k, i), 32'(gotq[i]), 32'(expq[i]));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req[k]   = 1'b0;
      din[k]   = 8'h00;
      ready[k] = 1'b1;
    end
    repeat (3) tick();
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_ack",   32'(ack[0]),   32'd0);
    chk("rst_cnt",   32'(cnt[0]),   32'd0);
    chk("rst_busy",  32'(busy[0]),  32'd0);
    chk("rst_data",  32'(dout[0]),  32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Four-phase latency: req set before edge 0, outputs update at edge 2.
    din[0] = 8'hA5;
    req[0] = 1'b1;
    tick();
    chk("t1_lat_e0", 32'(valid[0]), 32'd0);
    tick();
    chk("t1_lat_e1", 32'(valid[0]), 32'd0);
    tick();
    chk("t1_valid", 32'(valid[0]), 32'd1);
    chk("t1_data",  32'(dout[0]),  32'hA5);
    chk("t1_ack",   32'(ack[0]),   32'd1);
    chk("t1_cnt",   32'(cnt[0]),   32'd1);
    req[0] = 1'b0;
    tick();
    chk("t1_pop",       32'(valid[0]), 32'd0);
    chk("t1_busy_wait", 32'(busy[0]),  32'd1);
    tick();
    chk("t1_ack_hold", 32'(ack[0]), 32'd1);
    tick();
    chk("t1_ack_drop", 32'(ack[0]),  32'd0);
    chk("t1_busy_end", 32'(busy[0]), 32'd0);

    // Four-phase back-pressure.
    ready[0] = 1'b0;
    din[0] = 8'h11;
    req[0] = 1'b1;
    wait_ack(0, 1'b1);
    chk("t2_valid11", 32'(valid[0]), 32'd1);
    chk("t2_data11",  32'(dout[0]),  32'h11);
    req[0] = 1'b0;
    wait_ack(0, 1'b0);
    din[0] = 8'h22;
    req[0] = 1'b1;
    repeat (6) tick();
    chk("t2_stall_ack",  32'(ack[0]),   32'd0);
    chk("t2_stall_val",  32'(valid[0]), 32'd1);
    chk("t2_stall_data", 32'(dout[0]),  32'h11);
    chk("t2_stall_busy", 32'(busy[0]),  32'd1);
    chk("t2_stall_cnt",  32'(cnt[0]),   32'd2);
    ready[0] = 1'b1;
    tick();
    ready[0] = 1'b0;
    chk("t2_swap_val",  32'(valid[0]), 32'd1);
    chk("t2_swap_data", 32'(dout[0]),  32'h22);
    chk("t2_swap_ack",  32'(ack[0]),   32'd1);
    chk("t2_swap_cnt",  32'(cnt[0]),   32'd3);
    req[0] = 1'b0;
    wait_ack(0, 1'b0);
    ready[0] = 1'b1;
    tick();
    ready[0] = 1'b0;
    chk("t2_pop", 32'(valid[0]), 32'd0);

    // Asynchronous reset while in WAIT_LOW with a word held.
    din[0] = 8'h5A;
    req[0] = 1'b1;
    wait_ack(0, 1'b1);
    chk("t5_pre_valid", 32'(valid[0]), 32'd1);
    chk("t5_pre_cnt",   32'(cnt[0]),   32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ack",   32'(ack[0]),   32'd0);
    chk("t5_valid", 32'(valid[0]), 32'd0);
    chk("t5_cnt",   32'(cnt[0]),   32'd0);
    chk("t5_data",  32'(dout[0]),  32'd0);
    req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_busy",      32'(busy[0]),  32'd0);
    chk("t5_ack_after", 32'(ack[0]),   32'd0);
    chk("t5_val_after", 32'(valid[0]), 32'd0);
    ready[0] = 1'b1;

    // Toggle mode, four words.
    for (int i = 1; i <= 4; i++) begin
      din[1] = 8'(i);
      req[1] = ~req[1];
      wait_ack(1, req[1]);
      chk($sformatf("t3_valid%0d", i), 32'(valid[1]), 32'd1);
      chk($sformatf("t3_data%0d", i),  32'(dout[1]),  32'(i));
      tick();
      chk($sformatf("t3_beat%0d", i),  32'(valid[1]), 32'd0);
    end
    chk("t3_cnt", 32'(cnt[1]), 32'd4);

    // Counter wrap with CNT_W=2 in both modes.
    for (int k = 2; k < 4; k++) begin
      for (int i = 0; i < 5; i++) send(k, 8'(8'h30 + i));
      chk($sformatf("t4_wrap%0d", k), 32'(cnt[k]), 32'd1);
    end
    repeat (4) tick();

    for (int k = 0; k < 4; k++) stress(k);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cdc_bus_rx.md
Name: cdc_bus_rx

Overview:
- Receive side of a parametrised multi-bit clock-domain crossing. It is the successor to the single-bit fast-to-slow pulse crossing.
- It accepts a WIDTH-bit bus from an asynchronous sender using a req/ack handshake, in either four-phase or two-phase (toggle) mode.
- It returns ack to the sender and presents each captured word on a valid/ready stream in the local clock domain.
- Back-pressure is lossless: no new word is acknowledged while the output register is occupied.

Parameters:
- WIDTH, 8, data bus width in bits (>=1).
- SYNC_STAGES, 2, flops in the req synchroniser (>=2).
- TOGGLE_MODE, 0, handshake mode: 0 = four-phase level req/ack, 1 = two-phase toggle req/ack.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk_i  input  1  local clock.
- rst_ni  input  1  asynchronous active-low reset.
- async_req_i  input  1  request from the sender domain; asynchronous to clk_i.
- async_data_i  input  WIDTH  sender data; the sender holds it stable from req assertion/toggle until it sees ack.
- async_ack_o  output  1  acknowledge to the sender; registered, glitch-free.
- data_o  output  WIDTH  captured word.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts; transfer occurs when valid_o && ready_i.
- busy_o  output  1  handshake in progress or output occupied.
- xfer_cnt_o  output  CNT_W  count of words captured; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock (clk_i). Reset rst_ni is asynchronous, active-low.
- Reset values: all synchroniser flops 0, req_prev 0, async_ack_o 0, valid_o 0, data_o 0, busy_o 0, xfer_cnt_o 0, FSM in IDLE.
- Synchronisation: async_req_i passes through SYNC_STAGES flops to give req_s. async_data_i is never synchronised; it is sampled only on a capture, and the protocol guarantees it is stable then.
- slot_free = !valid_o || ready_i. A pop and a capture in the same cycle is legal; the new word replaces the old one with no bubble.
- Four-phase mode FSM:
  - IDLE: if req_s==1 && slot_free, capture: data_o<=async_data_i, valid_o<=1, async_ack_o<=1, xfer_cnt_o++, then go to WAIT_LOW. If req_s==1 && !slot_free, stay in IDLE with ack held 0, so the sender stalls.
  - WAIT_LOW: hold ack=1. When req_s==0, set async_ack_o<=0 and go to IDLE.
  - A new request is therefore only captured after the sender has seen ack drop and raised req again.
- Two-phase mode:
  - An event is req_s != req_prev.
  - On an event with slot_free, do the same capture and set async_ack_o<=req_s, req_prev<=req_s.
  - On an event without slot_free, the event stays pending (req_prev not updated) until slot_free.
  - The FSM stays in IDLE; WAIT_LOW is unused.
- Latency: an async_req_i edge meeting setup before clk edge 0 is in req_s after edge SYNC_STAGES-1. valid_o, data_o and ack update at edge SYNC_STAGES, i.e. SYNC_STAGES+1 cycles with the default (3 edges).
- Pop: valid_o<=0 on a cycle with valid_o && ready_i and no simultaneous capture.
- busy_o = (state != IDLE) || valid_o || (event pending or req_s==1 in IDLE).
- Counter: xfer_cnt_o increments exactly once per capture and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation clears any captured word and ack immediately. The sender domain must be reset together with this block. In toggle mode, a req left at 1 after reset is treated as one new event, which is documented sender responsibility.
- ready_i asserted with valid_o==0 has no effect.
- async_ack_o is driven directly from a flop; it never comes from combinational logic.

Decomposition:
- Package cdc_pkg:
  - state_e enum {IDLE, WAIT_LOW}.
  - Constant DEFAULT_SYNC_STAGES = 2.
- Sub-module cdc_sync_bit:
  - Parametrised N-stage single-bit synchroniser with async active-low reset.
  - Instantiated once, for async_req_i.

Test Plan:
1. Four-phase, ready_i=1: sender drives data 8'hA5 and raises req. valid_o rises 3 edges later with data_o=8'hA5, ack=1, xfer_cnt_o=1. After req drops, ack drops 3 edges later and busy_o returns to 0.
2. Four-phase back-pressure, ready_i=0: word 8'h11 is captured. Then req rises again for 8'h22; ack stays 0 and valid_o/data_o stay 8'h11. When ready_i is raised for one cycle, 8'h22 is captured in the same cycle as the pop, with no gap in valid_o.
3. Toggle mode, 4 words 8'h01..8'h04, ready_i=1: each req toggle yields one valid_o beat with the correct data. ack equals req after every capture; xfer_cnt_o=4.
4. Counter wrap with CNT_W=2: after 5 transfers, xfer_cnt_o=1.
5. Reset asserted while in WAIT_LOW with valid_o=1: ack, valid_o and xfer_cnt_o go to 0 immediately, without waiting for a clock edge. After release with req=0, the state is IDLE and busy_o=0.
6. Random stress: 100 words, random ready_i, sender waits on ack exactly as in the protocol. Output sequence equals input sequence with no loss or duplication, in both modes and for SYNC_STAGES of 2 and 3.
